// File: rtl/result_link_tx_if.sv
// rtl/result_link_tx_if.sv - signal bundle between the image side, the Arduino link and the result transmitter
interface result_link_tx_if;
  logic [2:0] result_in;
  logic       result_valid;
  logic       ard_req;
  logic       tx_data;
  logic       tx_clk;
  logic       tx_busy;
  logic [2:0] stable_result;

  modport master (
    output result_in, result_valid, ard_req,
    input  tx_data, tx_clk, tx_busy, stable_result
  );

  modport slave (
    input  result_in, result_valid, ard_req,
    output tx_data, tx_clk, tx_busy, stable_result
  );
endinterface

// File: rtl/result_link_tx.sv
// rtl/result_link_tx.sv - stability-filtered result code sent as a framed parity word on a strobe/data link
module result_link_tx #(
  parameter int STABLE_FRAMES = 3,
  parameter int BIT_CYCLES    = 50,
  parameter int DONE_TIMEOUT  = 1000000
) (
  input logic             clk,
  input logic             reset,
  result_link_tx_if.slave bus
);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CYC_HALF = CW'(BIT_CYCLES / 2);
  localparam logic [TW-1:0] TMO_LAST = TW'(DONE_TIMEOUT - 1);
  localparam logic [3:0]    SF       = 4'(STABLE_FRAMES);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t        state, state_nxt;
  logic [2:0]    cand;
  logic [3:0]    cnt;
  logic [2:0]    stable;
  logic          sync1, req_s;
  logic          rearm;
  logic [5:0]    shift_reg, shift_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [CW-1:0] cyc, cyc_nxt;
  logic [TW-1:0] tmo, tmo_nxt;
  logic          tx_data_q, tx_clk_q, tx_busy_q;
  logic          tx_data_nxt, tx_clk_nxt, tx_busy_nxt;
  logic          bit_end, timeout;

  // Filter keeps running regardless of link state; STABLE lags the threshold by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand   <= 3'b000;
      cnt    <= 4'd0;
      stable <= 3'b000;
    end else begin
      if (cnt == SF)
        stable <= cand;
      if (bus.result_valid) begin
        if (bus.result_in == cand) begin
          if (cnt != SF)
            cnt <= cnt + 4'd1;
        end else begin
          cand <= bus.result_in;
          cnt  <= 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      req_s <= 1'b0;
    end else begin
      sync1 <= bus.ard_req;
      req_s <= sync1;
    end
  end

  assign bit_end = (state == SEND) && (cyc == CYC_LAST);
  assign timeout = (tmo == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_s && !rearm) state_nxt = LOAD;
      LOAD: state_nxt = SEND;
      SEND: begin
        if (!req_s)
          state_nxt = IDLE;
        else if (bit_end && bit_idx == 3'd5)
          state_nxt = DONE;
      end
      DONE: if (!req_s || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shift_nxt = shift_reg;
    bit_nxt   = bit_idx;
    cyc_nxt   = cyc;
    tmo_nxt   = '0;
    case (state)
      LOAD: begin
        shift_nxt = {1'b1, stable, ^stable, 1'b0};
        bit_nxt   = 3'd0;
        cyc_nxt   = '0;
      end
      SEND: begin
        if (bit_end) begin
          shift_nxt = {shift_reg[4:0], 1'b0};
          cyc_nxt   = '0;
          bit_nxt   = bit_idx + 3'd1;
        end else begin
          cyc_nxt = cyc + 1'b1;
        end
      end
      DONE: tmo_nxt = tmo + 1'b1;
      default: ;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with the state they describe.
  always_comb begin
    tx_data_nxt = 1'b0;
    tx_clk_nxt  = 1'b0;
    tx_busy_nxt = (state_nxt != IDLE);
    if (state_nxt == SEND) begin
      tx_data_nxt = shift_nxt[5];
      tx_clk_nxt  = (cyc_nxt >= CYC_HALF);
    end
  end

  // After a timeout with the request still high, wait for it to drop before re-arming.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      bit_idx   <= '0;
      cyc       <= '0;
      tmo       <= '0;
      rearm     <= 1'b0;
      tx_data_q <= 1'b0;
      tx_clk_q  <= 1'b0;
      tx_busy_q <= 1'b0;
    end else begin
      shift_reg <= shift_nxt;
      bit_idx   <= bit_nxt;
      cyc       <= cyc_nxt;
      tmo       <= tmo_nxt;
      if (!req_s)
        rearm <= 1'b0;
      else if (state == DONE && timeout)
        rearm <= 1'b1;
      tx_data_q <= tx_data_nxt;
      tx_clk_q  <= tx_clk_nxt;
      tx_busy_q <= tx_busy_nxt;
    end
  end

  assign bus.tx_data       = tx_data_q;
  assign bus.tx_clk        = tx_clk_q;
  assign bus.tx_busy       = tx_busy_q;
  assign bus.stable_result = stable;
endmodule

// File: tb/tb_result_link_tx.sv
// tb/tb_result_link_tx.sv - self-checking bench for result_link_tx
module tb_result_link_tx;
  localparam int SF = 3;
  localparam int BC = 4;
  localparam int DT = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  result_link_tx_if bus();

  result_link_tx #(.STABLE_FRAMES(SF), .BIT_CYCLES(BC), .DONE_TIMEOUT(DT)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [2:0] code;
    logic [5:0] frame;
  } vec_t;

  vec_t       vecs[5];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [2:0] hist[$];
  logic [2:0] m_stable = 3'b000;
  logic       rise_bits[$];
  int         rise_cyc[$];
  int         cyc_no = 0;
  int         last_change = 0;
  logic       last_data = 1'b0;
  logic       prev_clk = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  function automatic bit run_ok();
    if (hist.size() < SF) return 1'b0;
    for (int i = 1; i < SF; i++)
      if (hist[hist.size() - 1 - i] != hist[hist.size() - 1]) return 1'b0;
    return 1'b1;
  endfunction

  // Reference filter: the output becomes the last value once the last SF valid samples agree.
  always @(posedge clk) begin
    if (reset) begin
      hist.delete();
      m_stable = 3'b000;
    end else begin
      if (run_ok()) m_stable = hist[$];
      if (bus.result_valid) hist.push_back(bus.result_in);
      if (hist.size() > 16) void'(hist.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_no++;
    if (bus.tx_data !== last_data) begin
      last_change = cyc_no;
      last_data   = bus.tx_data;
    end
    if (bus.tx_clk === 1'b1 && prev_clk === 1'b0) begin
      rise_bits.push_back(bus.tx_data);
      rise_cyc.push_back(cyc_no);
      check("data_setup", int'(cyc_no - last_change >= BC / 2), 1);
    end
    prev_clk = bus.tx_clk;
    check("stable_vs_model", int'(bus.stable_result), int'(m_stable));
  endtask

  task automatic set_stable(input logic [2:0] c);
    for (int i = 0; i < SF; i++) begin
      bus.result_in    = c;
      bus.result_valid = 1'b1;
      tick();
      bus.result_valid = 1'b0;
      tick();
    end
    check("stable_set", int'(bus.stable_result), int'(c));
  endtask

  task automatic xfer(input logic [5:0] fr, input bit inject, input logic [2:0] inj);
    int first_one;
    first_one = 0;
    rise_bits.delete();
    rise_cyc.delete();
    bus.ard_req = 1'b1;
    for (int i = 1; i <= 3 + 6 * BC + 1; i++) begin
      bus.result_valid = inject && i >= 8 && i <= 10;
      if (inject) bus.result_in = inj;
      tick();
      if (first_one == 0 && bus.tx_data === 1'b1) first_one = i;
    end
    bus.result_valid = 1'b0;
    check("start_latency", first_one, 4);
    check("rise_count", rise_bits.size(), 6);
    for (int b = 0; b < 6 && b < rise_bits.size(); b++)
      check("frame_bit", int'(rise_bits[b]), int'(fr[5 - b]));
    for (int b = 1; b < rise_cyc.size(); b++)
      check("rise_spacing", rise_cyc[b] - rise_cyc[b - 1], BC);
    check("done_busy", int'(bus.tx_busy), 1);
    check("done_clk", int'(bus.tx_clk), 0);
  endtask

  task automatic release_req(input int limit);
    int n;
    n = 0;
    bus.ard_req = 1'b0;
    do begin
      tick();
      n++;
    end while (bus.tx_busy !== 1'b0 && n < 8);
    check("busy_release", int'(n <= limit), 1);
    repeat (3) tick();
  endtask

  initial begin
    int n;
    int hi;
    logic [5:0] exp_fr;

    vecs[0] = '{code: 3'b110, frame: 6'b111000};
    vecs[1] = '{code: 3'b011, frame: 6'b101100};
    vecs[2] = '{code: 3'b000, frame: 6'b100000};
    vecs[3] = '{code: 3'b101, frame: 6'b110100};
    vecs[4] = '{code: 3'b001, frame: 6'b100110};

    reset = 1'b1;
    bus.ard_req = 1'b0;
    bus.result_valid = 1'b0;
    bus.result_in = 3'b000;
    repeat (3) tick();
    check("rst_tx_data", int'(bus.tx_data), 0);
    check("rst_tx_clk", int'(bus.tx_clk), 0);
    check("rst_tx_busy", int'(bus.tx_busy), 0);
    check("rst_stable", int'(bus.stable_result), 0);
    reset = 1'b0;
    repeat (2) tick();

    // Threshold latency and non-consecutive samples
    set_stable(3'b001);
    bus.result_in = 3'b101;
    bus.result_valid = 1'b1;
    repeat (3) tick();
    bus.result_valid = 1'b0;
    check("filter_before", int'(bus.stable_result), 1);
    tick();
    check("filter_after", int'(bus.stable_result), 5);
    for (int i = 0; i < 3; i++) begin
      bus.result_in = (i == 1) ? 3'b101 : 3'b110;
      bus.result_valid = 1'b1;
      tick();
      bus.result_valid = 1'b0;
      tick();
    end
    repeat (3) tick();
    check("filter_hold", int'(bus.stable_result), 5);

    for (int v = 0; v < 5; v++) begin
      set_stable(vecs[v].code);
      xfer(vecs[v].frame, 1'b0, 3'b000);
      repeat (6) tick();
      check("done_hold_busy", int'(bus.tx_busy), 1);
      check("done_no_strobe", rise_bits.size(), 6);
      release_req(3);
    end

    // Filter moves to a new value while the frame is in flight
    set_stable(3'b110);
    xfer(6'b111000, 1'b1, 3'b010);
    check("inflight_new_stable", int'(bus.stable_result), 2);
    release_req(3);

    // DONE timeout with the request held high
    set_stable(3'b010);
    xfer(6'b101010, 1'b0, 3'b000);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.tx_busy !== 1'b1) break;
      n++;
    end
    check("timeout_cycles", n + 1, DT);
    hi = 0;
    repeat (30) begin
      tick();
      if (bus.tx_busy !== 1'b0) hi++;
    end
    check("no_second_frame", hi, 0);
    check("no_strobe_after_timeout", rise_bits.size(), 6);
    bus.ard_req = 1'b0;
    repeat (4) tick();
    xfer(6'b101010, 1'b0, 3'b000);
    release_req(3);

    // Abort during bit 2
    set_stable(3'b011);
    rise_bits.delete();
    rise_cyc.delete();
    bus.ard_req = 1'b1;
    n = 0;
    while (rise_bits.size() < 3 && n < 60) begin
      tick();
      n++;
    end
    check("abort_reached_bit2", rise_bits.size(), 3);
    bus.ard_req = 1'b0;
    repeat (3) tick();
    check("abort_clk", int'(bus.tx_clk), 0);
    check("abort_data", int'(bus.tx_data), 0);
    check("abort_busy", int'(bus.tx_busy), 0);
    repeat (10) tick();
    check("abort_no_more_strobes", rise_bits.size(), 3);
    if (rise_bits.size() >= 3) begin
      check("abort_bit0", int'(rise_bits[0]), 1);
      check("abort_bit1", int'(rise_bits[1]), 0);
      check("abort_bit2", int'(rise_bits[2]), 1);
    end

    // Reset in the middle of SEND
    set_stable(3'b101);
    bus.ard_req = 1'b1;
    repeat (10) tick();
    check("pre_reset_busy", int'(bus.tx_busy), 1);
    reset = 1'b1;
    tick();
    check("mid_rst_clk", int'(bus.tx_clk), 0);
    check("mid_rst_data", int'(bus.tx_data), 0);
    check("mid_rst_busy", int'(bus.tx_busy), 0);
    check("mid_rst_stable", int'(bus.stable_result), 0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_busy1", int'(bus.tx_busy), 0);
    tick();
    check("post_rst_busy2", int'(bus.tx_busy), 0);
    tick();
    check("post_rst_load", int'(bus.tx_busy), 1);
    release_req(3);

    // Random filter traffic, then send whatever the model says is stable
    for (int it = 0; it < 4; it++) begin
      repeat (50) begin
        bus.result_valid = 1'($urandom_range(0, 1));
        bus.result_in    = 3'($urandom_range(1, 2 + it));
        tick();
      end
      bus.result_valid = 1'b0;
      repeat (2) tick();
      exp_fr = {1'b1, m_stable, ^m_stable, 1'b0};
      xfer(exp_fr, 1'b0, 3'b000);
      release_req(3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/result_link_tx.md
Name: result_link_tx

Overview:
- Transmitter end of the treasure-result link from the FPGA to the Arduino.
- Consumes the per-frame 3-bit shape/colour code from the image processor and passes it through an N-frame stability filter.
- On an Arduino request, serialises the stable code as a framed, parity-protected word on a two-wire strobe/data interface, then completes a four-phase request handshake.

Parameters:
- STABLE_FRAMES, 3: consecutive identical RESULT_VALID samples needed to update STABLE_RESULT (range 1..15).
- BIT_CYCLES, 50: CLK cycles per transmitted bit. Must be even and ≥4.
- DONE_TIMEOUT, 1000000: CLK cycles to wait for ARD_REQ to drop before forcing IDLE.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous reset, active-high.
- RESULT_IN  in  3  shape/colour code: 000 none; 001 blue square; 010 red square; 011 blue diamond; 100 red diamond; 101 blue triangle; 110 red triangle.
- RESULT_VALID  in  1  one-cycle pulse when RESULT_IN carries a new frame decision (once per VGA frame).
- ARD_REQ  in  1  Arduino request; asynchronous to CLK.
- TX_DATA  out  1  serial data, registered.
- TX_CLK  out  1  bit strobe, registered. Arduino samples TX_DATA on the TX_CLK rising edge.
- TX_BUSY  out  1  high from LOAD through DONE.
- STABLE_RESULT  out  3  filtered code; also the value transmitted.

Behaviour:
- Reset: all outputs 0. State IDLE. Candidate register = 000, count = 0, sync flops = 0, all counters = 0. RESET applies mid-frame too: any transfer is abandoned and TX_CLK/TX_DATA are low on the next cycle.

Stability filter (runs in every state):
- Update only on RESULT_VALID.
- If RESULT_IN == candidate: count saturates at STABLE_FRAMES.
- Otherwise: candidate <= RESULT_IN and count <= 1.
- STABLE_RESULT <= candidate on the cycle after count first equals STABLE_FRAMES, and holds until a different candidate reaches the threshold.
- STABLE_FRAMES = 1 means STABLE_RESULT follows RESULT_IN with 1 cycle latency after each RESULT_VALID.
- With RESULT_VALID low, nothing changes.

Request synchroniser:
- Two-flop synchroniser on ARD_REQ produces req_s.
- The FSM uses only req_s.

Frame format, 6 bits, MSB first:
- {1 (start), R[2], R[1], R[0], P, 0 (stop)}, with P = R[2]^R[1]^R[0] (even parity over R and P).
- R is STABLE_RESULT captured in LOAD. Later filter updates do not alter a frame in flight.

FSM:
- IDLE: TX_CLK = 0, TX_DATA = 0, TX_BUSY = 0. If req_s = 1, go to LOAD.
- LOAD (1 cycle): shift_reg <= frame, bit_idx <= 0, cyc <= 0, TX_BUSY = 1. Go to SEND.
- SEND:
  - TX_DATA = shift_reg[5].
  - TX_CLK = 0 for cyc in 0..BIT_CYCLES/2-1, and 1 for cyc in BIT_CYCLES/2..BIT_CYCLES-1.
  - At cyc = BIT_CYCLES-1: shift left, cyc <= 0, bit_idx++.
  - After bit 5 completes, go to DONE.
  - If req_s = 0 at any point in SEND: abort to IDLE next cycle, with TX_CLK/TX_DATA low.
- DONE: TX_CLK = 0, TX_DATA = 0, TX_BUSY = 1, and the timeout counter runs.
  - req_s = 0 → IDLE.
  - Timeout counter reaches DONE_TIMEOUT-1 → IDLE.
  - A new transfer needs req_s low then high again.

Latency:
- ARD_REQ first sampled high at edge k: LOAD entered at edge k+2, SEND at edge k+3.
- TX_DATA = 1 (start bit) is visible after edge k+3.
- Frame duration is 6×BIT_CYCLES cycles.
- TX_DATA changes only while TX_CLK is low, at bit boundaries, and is stable ≥ BIT_CYCLES/2 cycles before each rising TX_CLK.

Simultaneous events:
- RESULT_VALID in the LOAD cycle: the frame uses the pre-update STABLE_RESULT.
- RESET has priority over everything.

Test Plan:
- Reset: assert RESET 2 cycles mid-SEND → next cycle TX_CLK = 0, TX_DATA = 0, TX_BUSY = 0, STABLE_RESULT = 000; the FSM re-enters LOAD only after ARD_REQ is sampled high again.
- Filter, STABLE_FRAMES = 3:
  - RESULT_VALID pulses with 101, 101, 101 → STABLE_RESULT = 101 one cycle after the third pulse.
  - Then 110, 101, 110 → STABLE_RESULT stays 101.
- Frame content, BIT_CYCLES = 4: STABLE_RESULT = 110, raise ARD_REQ → bits sampled on TX_CLK rising edges are 1, 1, 1, 0, 0, 0. Exactly 6 TX_CLK rising edges, each 4 cycles apart; first TX_DATA = 1 three cycles after the first sampled ARD_REQ high.
- Parity: STABLE_RESULT = 011 → frame 1, 0, 1, 1, 0, 0. STABLE_RESULT = 000 → 1, 0, 0, 0, 0, 0.
- Handshake and abort:
  - Hold ARD_REQ high after the frame → TX_BUSY stays 1 in DONE with no further strobes; drop ARD_REQ → TX_BUSY = 0 within 3 cycles.
  - Drop ARD_REQ during bit 2 → TX_CLK low and IDLE within 3 cycles.
- In-flight stability and timeout:
  - Change the filter to a new stable value mid-SEND → the transmitted bits still match the value captured in LOAD.
  - With DONE_TIMEOUT = 20 and ARD_REQ held high → IDLE after 20 DONE cycles, and no second frame until ARD_REQ toggles low then high.
